alu_req_arbiter: RTL and testbench

Shares one 16-bit ALU datapath between two requesters. Each requester presents an operation on a valid/ready port; a round-robin arbiter grants one request per cycle and computes it on the embedded ALU. The result, flags and requester ID are held in a single response register drained by a valid/ready response port. The block sits between the instruction-issue logic and the ALU, so the ALU needs no handshake of its own.

---
 rtl/alu_req_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-port round-robin arbiter sharing one 16-bit ALU.
// One grant per cycle into a single valid/ready response register.
module alu_req_arbiter #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_a,
   input  logic [DATA_W-1:0] r0_b,
   input  logic [3:0]        r0_sel,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_a,
   input  logic [DATA_W-1:0] r1_b,
   input  logic [3:0]        r1_sel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic [3:0]        rsp_flags,
   output logic              rsp_err
);

   localparam int MSB = DATA_W - 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic              last_q;
   logic              can_accept;
   logic              gnt0;
   logic              gnt1;
   logic              gnt;

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [3:0]        op_sel;

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic              alu_v;
   logic              alu_err;
   logic [3:0]        alu_flags;

   // Readies stay low while reset is held even though the register is empty.
   assign can_accept = rst_n & (state_q == EMPTY | rsp_ready);

   assign r0_ready = can_accept & (last_q | ~r1_valid);
   assign r1_ready = can_accept & (~last_q | ~r0_valid);

   assign gnt0 = r0_valid & r0_ready;
   assign gnt1 = r1_valid & r1_ready;
   assign gnt  = gnt0 | gnt1;

   assign op_a   = gnt1 ? r1_a   : r0_a;
   assign op_b   = gnt1 ? r1_b   : r0_b;
   assign op_sel = gnt1 ? r1_sel : r0_sel;

   assign sum  = {1'b0, op_a} + {1'b0, op_b};
   assign diff = {1'b0, op_a} - {1'b0, op_b};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (op_sel)
         4'd0: begin
            alu_res = sum[MSB:0];
            alu_c   = sum[DATA_W];
            alu_v   = (op_a[MSB] == op_b[MSB])
                    & (sum[MSB] != op_a[MSB]);
         end
         4'd1: begin
            alu_res = diff[MSB:0];
            alu_c   = diff[DATA_W];
            alu_v   = (op_a[MSB] != op_b[MSB])
                    & (diff[MSB] != op_a[MSB]);
         end
         4'd2:    alu_res = op_a & op_b;
         4'd3:    alu_res = op_a ^ op_b;
         4'd4:    alu_res = op_a | op_b;
         4'd5:    alu_res = ~op_a;
         default: alu_err = 1'b1;
      endcase
   end

   assign alu_flags = {alu_c, (alu_res == '0), alu_res[MSB], alu_v};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (gnt) state_d = FULL;
         FULL:  if (rsp_ready && !gnt) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= 1'b1;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
      end else if (gnt) begin
         last_q     <= gnt1;
         rsp_id     <= gnt1;
         rsp_result <= alu_res;
         rsp_flags  <= alu_flags;
         rsp_err    <= alu_err;
      end
   end

   assign rsp_valid = (state_q == FULL);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter.
// Each task drives one scenario and checks against hand-computed values.
module tb_alu_req_arbiter;

   logic        clk;
   logic        rst_n;
   logic        r0_valid;
   logic        r0_ready;
   logic [15:0] r0_a;
   logic [15:0] r0_b;
   logic [3:0]  r0_sel;
   logic        r1_valid;
   logic        r1_ready;
   logic [15:0] r1_a;
   logic [15:0] r1_b;
   logic [3:0]  r1_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_err;

   int total;
   int bad;

   alu_req_arbiter #(.DATA_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .r0_valid   (r0_valid),
      .r0_ready   (r0_ready),
      .r0_a       (r0_a),
      .r0_b       (r0_b),
      .r0_sel     (r0_sel),
      .r1_valid   (r1_valid),
      .r1_ready   (r1_ready),
      .r1_a       (r1_a),
      .r1_b       (r1_b),
      .r1_sel     (r1_sel),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .rsp_err    (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      r0_valid  = 1'b1;
      r1_valid  = 1'b1;
      r0_a = 16'h0; r0_b = 16'h0; r0_sel = 4'd0;
      r1_a = 16'h0; r1_b = 16'h0; r1_sel = 4'd0;
      rsp_ready = 1'b1;
      #1;
      total++;
      if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready got r0=%b r1=%b want 0 0",
                  r0_ready, r1_ready);
      end
      tick();
      tick();
      total++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err} !== 23'h0) begin
         bad++;
         $display("FAIL reset_rsp got v=%b id=%b r=%h f=%b e=%b want all 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      r0_valid = 1'b1;
      r0_a = 16'h7FFF; r0_b = 16'h0001; r0_sel = 4'd0;
      rsp_ready = 1'b1;
      #1;
      total++;
      if (r0_ready !== 1'b1) begin
         bad++;
         $display("FAIL add_ready got %b want 1", r0_ready);
      end
      tick();
      r0_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'h8000
          || rsp_flags !== 4'b0011 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL add_rsp got v=%b id=%b r=%h f=%b e=%b want 1 0 8000 0011 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
      tick();
      total++;
      if (rsp_valid !== 1'b0 || rsp_result !== 16'h8000) begin
         bad++;
         $display("FAIL add_drain got v=%b r=%h want 0 8000",
                  rsp_valid, rsp_result);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_alternate();
      logic [15:0] exp_r;
      logic [3:0]  exp_f;
      logic        exp_id;
      pulse_reset();
      r0_a = 16'h0005; r0_b = 16'h0007; r0_sel = 4'd1;
      r1_a = 16'h0003; r1_b = 16'h0003; r1_sel = 4'd1;
      r0_valid  = 1'b1;
      r1_valid  = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_id = (i % 2 == 1);
         exp_r  = exp_id ? 16'h0000 : 16'hFFFE;
         exp_f  = exp_id ? 4'b0100 : 4'b1010;
         total++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp_id
             || rsp_result !== exp_r || rsp_flags !== exp_f) begin
            bad++;
            $display("FAIL alt[%0d] got v=%b id=%b r=%h f=%b want 1 %b %h %b",
                     i, rsp_valid, rsp_id, rsp_result, rsp_flags,
                     exp_id, exp_r, exp_f);
         end
      end
      r0_valid = 1'b0;
   endtask

   task automatic test_stall();
      rsp_ready = 1'b0;
      r1_valid  = 1'b1;
      r1_a = 16'h0001; r1_b = 16'h0002; r1_sel = 4'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (r1_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 1'b1
             || rsp_result !== 16'h0000 || rsp_flags !== 4'b0100) begin
            bad++;
            $display("FAIL stall[%0d] got rdy=%b v=%b id=%b r=%h f=%b want 0 1 1 0000 0100",
                     i, r1_ready, rsp_valid, rsp_id, rsp_result, rsp_flags);
         end
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      total++;
      if (r1_ready !== 1'b1) begin
         bad++;
         $display("FAIL stall_release got rdy=%b want 1", r1_ready);
      end
      tick();
      r1_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'h0003
          || rsp_flags !== 4'b0000) begin
         bad++;
         $display("FAIL stall_rsp got v=%b id=%b r=%h f=%b want 1 1 0003 0000",
                  rsp_valid, rsp_id, rsp_result, rsp_flags);
      end
   endtask

   task automatic test_illegal();
      rsp_ready = 1'b1;
      r1_valid  = 1'b1;
      r1_a = 16'h1234; r1_b = 16'h5678; r1_sel = 4'b1010;
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'h0000
          || rsp_flags !== 4'b0100 || rsp_err !== 1'b1) begin
         bad++;
         $display("FAIL illegal got v=%b id=%b r=%h f=%b e=%b want 1 1 0000 0100 1",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
      r1_a = 16'h00FF; r1_b = 16'h0000; r1_sel = 4'd5;
      tick();
      r1_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'hFF00
          || rsp_flags !== 4'b0010 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL not_a got v=%b id=%b r=%h f=%b e=%b want 1 1 ff00 0010 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      tick();
      r0_valid = 1'b1;
      r0_a = 16'h0001; r0_b = 16'h0001; r0_sel = 4'd0;
      rsp_ready = 1'b1;
      tick();
      r0_valid  = 1'b0;
      rsp_ready = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h0002) begin
         bad++;
         $display("FAIL mid_pre got v=%b r=%h want 1 0002",
                  rsp_valid, rsp_result);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || rsp_result !== 16'h0000 || r1_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got v=%b r=%h rdy1=%b want 0 0000 0",
                  rsp_valid, rsp_result, r1_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      r0_a = 16'h0010; r0_b = 16'h0020; r0_sel = 4'd0;
      r1_a = 16'hF0F0; r1_b = 16'h0FF0; r1_sel = 4'd2;
      r0_valid  = 1'b1;
      r1_valid  = 1'b1;
      rsp_ready = 1'b1;
      #1;
      total++;
      if (r0_ready !== 1'b1 || r1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_ready got r0=%b r1=%b v=%b want 1 0 0",
                  r0_ready, r1_ready, rsp_valid);
      end
      tick();
      r0_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 16'h0030) begin
         bad++;
         $display("FAIL mid_first got v=%b id=%b r=%h want 1 0 0030",
                  rsp_valid, rsp_id, rsp_result);
      end
      tick();
      r1_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'h00F0
          || rsp_flags !== 4'b0000) begin
         bad++;
         $display("FAIL mid_second got v=%b id=%b r=%h f=%b want 1 1 00f0 0000",
                  rsp_valid, rsp_id, rsp_result, rsp_flags);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_add();
      test_alternate();
      test_stall();
      test_illegal();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
